// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and helpers for the matrix keypad scanner.
//   scan_state_e   - per-column slot phases of the scan FSM
//   frame_result_e - classification of one complete scan frame
//   hex_legend()   - key index (row*4+col) to legend nibble for the standard 4x4 pad
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN_DRIVE  = 2'd0,   // column driven, rows settling
        SCAN_SAMPLE = 2'd1,   // synchronized rows captured into the bitmap
        SCAN_HOLD   = 2'd2    // waiting out the rest of the column slot
    } scan_state_e;

    typedef enum logic [1:0] {
        FRAME_NONE   = 2'd0,
        FRAME_SINGLE = 2'd1,
        FRAME_MULTI  = 2'd2
    } frame_result_e;

    // Legend of the standard 4x4 pad. Columns read top to bottom:
    // col0 = 1,4,7,0  col1 = 2,5,8,F  col2 = 3,6,9,E  col3 = A,B,C,D
    function automatic logic [3:0] hex_legend(input logic [3:0] idx);
        logic [3:0] legend;
        case (idx)
            4'd0:    legend = 4'h1;
            4'd1:    legend = 4'h2;
            4'd2:    legend = 4'h3;
            4'd3:    legend = 4'hA;
            4'd4:    legend = 4'h4;
            4'd5:    legend = 4'h5;
            4'd6:    legend = 4'h6;
            4'd7:    legend = 4'hB;
            4'd8:    legend = 4'h7;
            4'd9:    legend = 4'h8;
            4'd10:   legend = 4'h9;
            4'd11:   legend = 4'hC;
            4'd12:   legend = 4'h0;
            4'd13:   legend = 4'hF;
            4'd14:   legend = 4'hE;
            default: legend = 4'hD;
        endcase
        return legend;
    endfunction

endpackage

// File: rtl/keypad_frame_debounce.sv
// keypad_frame_debounce: frame-level debounce, one-shot reporting, multi-key
// rejection and optional auto-repeat.
//   clk, rst_n   - clock, synchronous active-low reset
//   frame_end    - one-cycle strobe, frame_result/frame_idx valid with it
//   frame_result - NONE / SINGLE / MULTI for the frame just completed
//   frame_idx    - key index when SINGLE, zero otherwise
//   key_valid    - one-cycle report pulse (first press and each repeat)
//   key_idx      - index of the last report, held between reports
//   key_held     - a debounced single key is down
//   multi_key    - last debounced frame held more than one key
module keypad_frame_debounce
    import keypad_pkg::*;
#(
    parameter int IDX_W           = 4,
    parameter int DEBOUNCE_FRAMES = 4,
    parameter int REPEAT_EN       = 0,
    parameter int REPEAT_DELAY    = 500,
    parameter int REPEAT_RATE     = 100
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             frame_end,
    input  frame_result_e    frame_result,
    input  logic [IDX_W-1:0] frame_idx,
    output logic             key_valid,
    output logic [IDX_W-1:0] key_idx,
    output logic             key_held,
    output logic             multi_key
);

    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW      = $clog2(REP_MAX + 1);
    localparam int SW      = $clog2(DEBOUNCE_FRAMES + 1);

    frame_result_e    prev_result;
    logic [IDX_W-1:0] prev_idx;
    logic [SW-1:0]    stable_cnt;
    logic             armed;
    logic [RW-1:0]    rep_cnt;     // frames since report or since last repeat
    logic             rep_first;   // next repeat uses REPEAT_DELAY, not REPEAT_RATE

    logic [SW-1:0]    cnt_next;
    logic             settled;
    logic             report;
    logic             release_ev;
    logic             multi_ev;
    logic [RW-1:0]    rep_inc;
    logic [RW-1:0]    rep_limit;
    logic             rep_fire;

    always_comb begin
        cnt_next   = SW'(1);
        settled    = 1'b0;
        report     = 1'b0;
        release_ev = 1'b0;
        multi_ev   = 1'b0;
        rep_inc    = RW'(rep_cnt + RW'(1));
        rep_limit  = rep_first ? RW'(REPEAT_DELAY) : RW'(REPEAT_RATE);
        rep_fire   = 1'b0;

        // A SINGLE result only matches when the key index matches too, so
        // sliding from one key to another restarts the debounce.
        if ((frame_result == prev_result) && (frame_idx == prev_idx)) begin
            if (stable_cnt == SW'(DEBOUNCE_FRAMES))
                cnt_next = stable_cnt;
            else
                cnt_next = SW'(stable_cnt + SW'(1));
        end

        settled    = (cnt_next == SW'(DEBOUNCE_FRAMES));
        report     = settled && (frame_result == FRAME_SINGLE) && armed;
        release_ev = settled && (frame_result == FRAME_NONE);
        multi_ev   = settled && (frame_result == FRAME_MULTI);

        // Repeats never coincide with a report or with key_held falling.
        rep_fire = (REPEAT_EN != 0) && key_held && !report && !release_ev &&
                   !multi_ev && (rep_inc >= rep_limit);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_result <= FRAME_NONE;
            prev_idx    <= '0;
            stable_cnt  <= '0;
            armed       <= 1'b1;
            rep_cnt     <= '0;
            rep_first   <= 1'b1;
            key_valid   <= 1'b0;
            key_idx     <= '0;
            key_held    <= 1'b0;
            multi_key   <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            if (frame_end) begin
                prev_result <= frame_result;
                prev_idx    <= frame_idx;
                stable_cnt  <= cnt_next;

                if (report) begin
                    key_valid <= 1'b1;
                    key_idx   <= frame_idx;
                    key_held  <= 1'b1;
                    armed     <= 1'b0;
                end
                if (release_ev) begin
                    key_held  <= 1'b0;
                    multi_key <= 1'b0;
                    armed     <= 1'b1;
                end
                if (multi_ev) begin
                    key_held  <= 1'b0;
                    multi_key <= 1'b1;
                end

                if (report || release_ev || multi_ev || !key_held) begin
                    rep_cnt   <= '0;
                    rep_first <= 1'b1;
                end else if (rep_fire) begin
                    key_valid <= 1'b1;
                    rep_cnt   <= '0;
                    rep_first <= 1'b0;
                end else if (REPEAT_EN != 0) begin
                    rep_cnt   <= rep_inc;
                end
            end
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: matrix keypad scanner. Drives one active-low column per
// slot, samples synchronized active-low rows into a frame bitmap, classifies
// each frame and hands it to keypad_frame_debounce.
//   clk, rst_n - clock, synchronous active-low reset
//   row        - keypad rows, active-low, asynchronous
//   col        - column drive, active-low, at most one bit low
//   key_valid  - one-cycle report pulse
//   key_idx    - reported key, row*N_COLS+col, held until next report
//   key_held   - debounced single key down
//   multi_key  - last debounced frame held several keys
// SETTLE_CYCLES must be >= 3 (two synchronizer stages plus settling) and
// below SCAN_CYCLES.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int N_ROWS          = 4,
    parameter int N_COLS          = 4,
    parameter int SCAN_CYCLES     = 100000,
    parameter int SETTLE_CYCLES   = 8,
    parameter int DEBOUNCE_FRAMES = 4,
    parameter int REPEAT_EN       = 0,
    parameter int REPEAT_DELAY    = 500,
    parameter int REPEAT_RATE     = 100
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [N_ROWS-1:0]                   row,
    output logic [N_COLS-1:0]                   col,
    output logic                                key_valid,
    output logic [$clog2(N_ROWS*N_COLS)-1:0]    key_idx,
    output logic                                key_held,
    output logic                                multi_key
);

    localparam int KEYS  = N_ROWS * N_COLS;
    localparam int IDX_W = $clog2(KEYS);
    localparam int CW    = (N_COLS > 1) ? $clog2(N_COLS) : 1;
    localparam int TW    = $clog2(SCAN_CYCLES);

    logic [N_ROWS-1:0] row_meta;
    logic [N_ROWS-1:0] row_sync;

    // scan_en is low only in the first cycle after reset; it holds the slot
    // counters at t=0 while the column register loads, so the column goes low
    // exactly when slot 0 begins.
    logic              scan_en;
    scan_state_e       state, state_next;
    logic [TW-1:0]     t_cnt, t_next;
    logic [CW-1:0]     c_cnt, c_next;
    logic              frame_end;

    logic [KEYS-1:0]   frame_bits, frame_next;
    logic [1:0]        hits;        // saturates at 2: "more than one"
    logic [IDX_W-1:0]  hit_idx;
    frame_result_e     frame_result;
    logic [IDX_W-1:0]  frame_idx;

    // Scan FSM: next state and slot/column counters.
    always_comb begin
        state_next = state;
        t_next     = t_cnt;
        c_next     = c_cnt;
        frame_end  = 1'b0;
        if (scan_en) begin
            if (t_cnt == TW'(SCAN_CYCLES - 1)) begin
                t_next     = '0;
                state_next = SCAN_DRIVE;
                if (c_cnt == CW'(N_COLS - 1)) begin
                    c_next    = '0;
                    frame_end = 1'b1;
                end else begin
                    c_next = CW'(c_cnt + CW'(1));
                end
            end else begin
                t_next = TW'(t_cnt + TW'(1));
                case (state)
                    SCAN_DRIVE:  if (t_cnt == TW'(SETTLE_CYCLES - 1)) state_next = SCAN_SAMPLE;
                    SCAN_SAMPLE: state_next = SCAN_HOLD;
                    default:     state_next = SCAN_HOLD;
                endcase
            end
        end
    end

    // Frame bitmap update: the active column's bits are overwritten each
    // slot, so the map is complete by the frame-end strobe without clearing.
    always_comb begin
        frame_next = frame_bits;
        if (state == SCAN_SAMPLE) begin
            for (int r = 0; r < N_ROWS; r++) begin
                for (int c = 0; c < N_COLS; c++) begin
                    if (CW'(c) == c_cnt)
                        frame_next[r*N_COLS + c] = ~row_sync[r];
                end
            end
        end
    end

    // Frame classification.
    always_comb begin
        hits    = 2'd0;
        hit_idx = '0;
        for (int i = 0; i < KEYS; i++) begin
            if (frame_bits[i]) begin
                if (hits == 2'd0) hit_idx = IDX_W'(i);
                if (hits != 2'd2) hits = hits + 2'd1;
            end
        end
        frame_result = FRAME_NONE;
        frame_idx    = '0;
        if (hits == 2'd1) begin
            frame_result = FRAME_SINGLE;
            frame_idx    = hit_idx;
        end else if (hits == 2'd2) begin
            frame_result = FRAME_MULTI;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            row_meta   <= '1;
            row_sync   <= '1;
            scan_en    <= 1'b0;
            state      <= SCAN_DRIVE;
            t_cnt      <= '0;
            c_cnt      <= '0;
            col        <= '1;
            frame_bits <= '0;
        end else begin
            row_meta   <= row;
            row_sync   <= row_meta;
            scan_en    <= 1'b1;
            state      <= state_next;
            t_cnt      <= t_next;
            c_cnt      <= c_next;
            col        <= ~(N_COLS'(1) << c_next);
            frame_bits <= frame_next;
        end
    end

    keypad_frame_debounce #(
        .IDX_W           (IDX_W),
        .DEBOUNCE_FRAMES (DEBOUNCE_FRAMES),
        .REPEAT_EN       (REPEAT_EN),
        .REPEAT_DELAY    (REPEAT_DELAY),
        .REPEAT_RATE     (REPEAT_RATE)
    ) u_debounce (
        .clk          (clk),
        .rst_n        (rst_n),
        .frame_end    (frame_end),
        .frame_result (frame_result),
        .frame_idx    (frame_idx),
        .key_valid    (key_valid),
        .key_idx      (key_idx),
        .key_held     (key_held),
        .multi_key    (multi_key)
    );

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: bench for keypad_scanner with 16-cycle slots, 4-cycle
// settle, 3-frame debounce on a 4x4 pad (64-cycle frames). Two instances:
// u_dut without repeat, u_dut_rep with repeat (delay 5, rate 2 frames).
// Each has a behavioural keypad model closing row to col for pressed keys.
module tb_keypad_scanner;
    import keypad_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    // ---------------- DUT signals ----------------
    logic [15:0] keys, keys_r;
    logic [3:0]  row, row_r, col, col_r;
    logic        key_valid, kv_r;
    logic [3:0]  key_idx, idx_r;
    logic        key_held, held_r, multi_key, multi_r;

    always_comb begin
        row   = 4'b1111;
        row_r = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[r*4 + c] && !col[c])     row[r]   = 1'b0;
                if (keys_r[r*4 + c] && !col_r[c]) row_r[r] = 1'b0;
            end
        end
    end

    keypad_scanner #(
        .N_ROWS(4), .N_COLS(4), .SCAN_CYCLES(16), .SETTLE_CYCLES(4),
        .DEBOUNCE_FRAMES(3), .REPEAT_EN(0), .REPEAT_DELAY(500), .REPEAT_RATE(100)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .row(row), .col(col),
        .key_valid(key_valid), .key_idx(key_idx),
        .key_held(key_held), .multi_key(multi_key)
    );

    keypad_scanner #(
        .N_ROWS(4), .N_COLS(4), .SCAN_CYCLES(16), .SETTLE_CYCLES(4),
        .DEBOUNCE_FRAMES(3), .REPEAT_EN(1), .REPEAT_DELAY(5), .REPEAT_RATE(2)
    ) u_dut_rep (
        .clk(clk), .rst_n(rst_n), .row(row_r), .col(col_r),
        .key_valid(kv_r), .key_idx(idx_r),
        .key_held(held_r), .multi_key(multi_r)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;
    int frame_no = 0;      // bumps on the first cycle of each frame (col0 low)
    int n_kv     = 0;
    int n_kv_r   = 0;
    logic [3:0]  prev_col = 4'b1111;
    logic        kv_prev = 1'b0, kv_r_prev = 1'b0;
    logic [19:0] exp_q[$];  // {report frame[15:0], key idx} for u_dut
    logic [19:0] rep_q[$];  // same for u_dut_rep
    logic [19:0] e;
    logic [15:0] fr16;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, required 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (col == 4'b1110 && prev_col != 4'b1110) frame_no = frame_no + 1;
        prev_col = col;
        fr16 = frame_no[15:0];
        if (key_valid) begin
            n_kv++;
            check_eq("kv_one_cycle", {31'd0, kv_prev}, 0);
            if (exp_q.size() == 0) begin
                check_eq("sb_extra_pulse", exp_q.size(), 1);
            end else begin
                e = exp_q.pop_front();
                check_eq("sb_report", {12'd0, fr16, key_idx}, {12'd0, e});
            end
        end
        kv_prev = key_valid;
        if (kv_r) begin
            n_kv_r++;
            check_eq("rep_one_cycle", {31'd0, kv_r_prev}, 0);
            if (rep_q.size() == 0) begin
                check_eq("rep_extra_pulse", rep_q.size(), 1);
            end else begin
                e = rep_q.pop_front();
                check_eq("rep_report", {12'd0, fr16, idx_r}, {12'd0, e});
            end
        end
        kv_r_prev = kv_r;
    end

    // ---------------- driver tasks ----------------
    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    // Returns just after the negedge of the first cycle of the n-th next frame.
    task automatic wait_frames(input int n);
        int target;
        int guard;
        target = frame_no + n;
        guard  = 0;
        while (frame_no < target && guard < n * 64 + 80) begin
            @(negedge clk);
            #1;
            guard++;
        end
        check_eq("frame_wait", {31'd0, frame_no >= target}, 1);
    endtask

    // Press at a frame start: report expected three frames later.
    task automatic press(input int idx);
        logic [15:0] f;
        keys[idx] = 1'b1;
        f = 16'(frame_no + 3);
        exp_q.push_back({f, 4'(idx)});
    endtask

    // ---------------- stimulus ----------------
    int base;
    int kv_before;

    initial begin
        rst_n  = 1'b0;
        keys   = '0;
        keys_r = '0;
        wait_cycles(4);
        check_eq("rst_col",       col, 4'b1111);
        check_eq("rst_col_rep",   col_r, 4'b1111);
        check_eq("rst_key_valid", key_valid, 0);
        check_eq("rst_key_idx",   key_idx, 0);
        check_eq("rst_key_held",  key_held, 0);
        check_eq("rst_multi_key", multi_key, 0);
        rst_n = 1'b1;
        wait_cycles(1);
        check_eq("first_col", col, 4'b1110);

        check_eq("legend_6",  hex_legend(4'd6),  4'h6);
        check_eq("legend_3",  hex_legend(4'd3),  4'hA);
        check_eq("legend_12", hex_legend(4'd12), 4'h0);
        check_eq("legend_13", hex_legend(4'd13), 4'hF);

        wait_frames(4);

        // 1: key 6 (row1, col2) held 5 frames -> one report
        press(6);
        wait_frames(2);
        check_eq("t1_held_early", key_held, 0);
        wait_frames(1);
        check_eq("t1_valid", key_valid, 1);
        check_eq("t1_held",  key_held, 1);
        check_eq("t1_idx",   key_idx, 6);
        wait_frames(2);
        keys = '0;
        wait_frames(4);
        check_eq("t1_released", key_held, 0);
        check_eq("t1_one_report", n_kv, 1);

        // 2: bouncy 2-frame presses never debounce
        kv_before = n_kv;
        for (int i = 0; i < 4; i++) begin
            keys[6] = 1'b1;
            wait_frames(2);
            keys[6] = 1'b0;
            wait_frames(2);
        end
        wait_frames(2);
        check_eq("t2_no_report", n_kv, kv_before);
        check_eq("t2_not_held", key_held, 0);

        // 3: 6 then 9 together -> multi; drop 6 -> no report for 9
        press(6);
        wait_frames(4);
        keys[9] = 1'b1;
        wait_frames(3);
        check_eq("t3_multi", multi_key, 1);
        check_eq("t3_held_clr", key_held, 0);
        check_eq("t3_idx_kept", key_idx, 6);
        kv_before = n_kv;
        keys[6] = 1'b0;
        wait_frames(5);
        check_eq("t3_no_report_9", n_kv, kv_before);
        check_eq("t3_9_not_held", key_held, 0);
        keys = '0;
        wait_frames(4);
        check_eq("t3_multi_clr", multi_key, 0);

        // 4: press, 3-frame release, press again -> two reports
        press(5);
        wait_frames(3);
        check_eq("t4_idx_a", key_idx, 5);
        wait_frames(1);
        keys = '0;
        wait_frames(3);
        press(15);
        wait_frames(4);
        check_eq("t4_idx_b", key_idx, 15);
        keys = '0;
        wait_frames(4);

        // 5: auto-repeat on key 0 held 12 frames
        base = frame_no;
        keys_r[0] = 1'b1;
        rep_q.push_back({16'(base + 3),  4'd0});
        rep_q.push_back({16'(base + 8),  4'd0});
        rep_q.push_back({16'(base + 10), 4'd0});
        rep_q.push_back({16'(base + 12), 4'd0});
        rep_q.push_back({16'(base + 14), 4'd0});
        wait_frames(12);
        keys_r = '0;
        wait_frames(5);
        check_eq("t5_held_clr", held_r, 0);
        check_eq("t5_pulses", n_kv_r, 5);
        check_eq("t5_rep_q_empty", rep_q.size(), 0);

        // 6: reset mid-debounce
        keys[10] = 1'b1;
        wait_frames(2);
        wait_cycles(30);
        rst_n = 1'b0;
        wait_cycles(1);
        check_eq("t6_col",       col, 4'b1111);
        check_eq("t6_col_rep",   col_r, 4'b1111);
        check_eq("t6_key_valid", key_valid, 0);
        check_eq("t6_key_idx",   key_idx, 0);
        check_eq("t6_key_held",  key_held, 0);
        check_eq("t6_multi_key", multi_key, 0);
        keys = '0;
        wait_cycles(2);
        rst_n = 1'b1;
        wait_cycles(1);
        check_eq("t6_first_col", col, 4'b1110);
        kv_before = n_kv;
        wait_frames(4);
        check_eq("t6_pending_dropped", n_kv, kv_before);
        press(10);
        wait_frames(4);
        check_eq("t6_rearmed_held", key_held, 1);
        check_eq("t6_rearmed_idx", key_idx, 10);
        keys = '0;
        wait_frames(4);

        check_eq("exp_q_empty", exp_q.size(), 0);
        check_eq("rep_q_empty", rep_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout, required end of stimulus");
        $fatal(1, "watchdog");
    end

endmodule
